// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit
//
// Purpose: executes one RV32M multiply or divide per request using one
// shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
// Divide-by-zero and signed overflow are answered through a fast path.
//
// Ports:
//   clk     in   clock, all state updates on rising edge
//   reset   in   synchronous active-high reset
//   start   in   request, sampled only while busy=0
//   kill    in   abort the in-flight operation, wins over start
//   Funct3  in   RV32M op (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   op_a    in   rs1 operand (multiplicand / dividend)
//   op_b    in   rs2 operand (multiplier / divisor)
//   busy    out  high from the cycle after acceptance through the done cycle
//   done    out  one-cycle pulse, result valid
//   result  out  registered result, held until the next completion
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2:0]           fn_q, fn_d;
  logic                 neg_q, neg_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     result_q, result_d;

  // Request decode
  logic             a_neg, b_neg, div_zero, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag, fast_res;

  assign a_neg    = (Funct3 inside {3'b001, 3'b010, 3'b100, 3'b110}) && op_a[WIDTH-1];
  assign b_neg    = (Funct3 inside {3'b001, 3'b100, 3'b110}) && op_b[WIDTH-1];
  assign a_mag    = a_neg ? -op_a : op_a;
  assign b_mag    = b_neg ? -op_b : op_b;
  assign div_zero = Funct3[2] && (op_b == {WIDTH{1'b0}});
  assign div_ovf  = Funct3[2] && !Funct3[0] && (op_b == {WIDTH{1'b1}}) &&
                    (op_a == {1'b1, {(WIDTH-1){1'b0}}});
  // Funct3[1] separates REM/REMU from DIV/DIVU within the divide group.
  assign fast_res = div_zero ? (Funct3[1] ? op_a : {WIDTH{1'b1}})
                             : (Funct3[1] ? {WIDTH{1'b0}} : op_a);

  // Iteration datapath
  logic [WIDTH:0]       mul_sum, rem_sh, rem_diff;
  logic [WIDTH-1:0]     rem_new, quo_fix, rem_fix, fix_res;
  logic [2*WIDTH-1:0]   prod_fix;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, b_q};
  // Borrow out means the divisor did not fit: restore the shifted remainder.
  assign rem_new  = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign fix_res  = fn_q[2] ? (fn_q[1] ? rem_fix : quo_fix)
                            : ((fn_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0]
                                                    : prod_fix[2*WIDTH-1:WIDTH]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    fn_d     = fn_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    result_d = result_q;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          // done_q still high means this is the done cycle: busy, so no accept.
          if (start && !done_q) begin
            fn_d  = Funct3;
            b_d   = b_mag;
            cnt_d = {CNT_W{1'b0}};
            // Remainder takes the dividend's sign; everything else the xor.
            neg_d = (Funct3[2] && Funct3[1]) ? a_neg : (a_neg ^ b_neg);
            if (div_zero || div_ovf) begin
              acc_d   = {{WIDTH{1'b0}}, fast_res};
              state_d = S_DONE;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, a_mag};
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (fn_q[2]) acc_d = {rem_new, acc_q[WIDTH-2:0], ~rem_diff[WIDTH]};
          else         acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
        S_FIX: begin
          acc_d[WIDTH-1:0] = fix_res;
          state_d          = S_DONE;
        end
        S_DONE: begin
          done_d   = 1'b1;
          result_d = acc_q[WIDTH-1:0];
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      b_q      <= {WIDTH{1'b0}};
      fn_q     <= 3'b000;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      fn_q     <= fn_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE) || done_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        kill;
  logic [2:0]  Funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [7:0]  lat;
  } vec_t;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .Funct3(Funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at posedge+1. Issues one request (optionally holding start high
  // with scrambled operands while busy and through the done cycle), then
  // reports what was observed. Latency counts edges after the accept edge.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic hold, output int lat, output logic [31:0] res,
                        output logic busy_at_done, output logic quiet_after,
                        output logic stable);
    logic [31:0] prev;
    prev   = result;
    stable = 1'b1;
    Funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    if (hold) begin op_a = ~a; op_b = b + 32'd3; Funct3 = ~f; end
    else start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (result !== prev) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res          = result;
    busy_at_done = busy;
    @(posedge clk); #1;
    quiet_after = (done === 1'b0) && (busy === 1'b0);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; kill = 1'b1; Funct3 = 3'b000; op_a = 32'd5; op_b = 32'd5;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
    reset = 1'b0; start = 1'b0; kill = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    vec_t v [5];
    int lat; logic [31:0] res; logic bd, qa, st;
    v[0] = '{3'b000, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFF9, 8'd34};
    v[1] = '{3'b011, 32'hFFFFFFFF, 32'h00000007, 32'h00000006, 8'd34};
    v[2] = '{3'b001, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFFF, 8'd34};
    v[3] = '{3'b010, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFFF, 8'd34};
    v[4] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 8'd34};
    for (int i = 0; i < 5; i++) begin
      run_op(v[i].f, v[i].a, v[i].b, 1'b0, lat, res, bd, qa, st);
      checks++; if (res !== v[i].r) begin errors++; $display("FAIL mul[%0d]_result got %h exp %h", i, res, v[i].r); end
      checks++; if (lat != int'(v[i].lat)) begin errors++; $display("FAIL mul[%0d]_latency got %0d exp %0d", i, lat, v[i].lat); end
      checks++; if (!(bd && qa && st)) begin errors++; $display("FAIL mul[%0d]_handshake got busy_done=%b quiet=%b stable=%b exp 111", i, bd, qa, st); end
    end
  endtask

  task automatic test_div();
    vec_t v [6];
    int lat; logic [31:0] res; logic bd, qa, st;
    v[0] = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 8'd34};
    v[1] = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 8'd34};
    v[2] = '{3'b101, 32'd100,      32'd7,        32'd14,       8'd34};
    v[3] = '{3'b111, 32'd100,      32'd7,        32'd2,        8'd34};
    v[4] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 8'd34};
    v[5] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        8'd34};
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].f, v[i].a, v[i].b, 1'b0, lat, res, bd, qa, st);
      checks++; if (res !== v[i].r) begin errors++; $display("FAIL div[%0d]_result got %h exp %h", i, res, v[i].r); end
      checks++; if (lat != int'(v[i].lat)) begin errors++; $display("FAIL div[%0d]_latency got %0d exp %0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_fast_path();
    vec_t v [5];
    int lat; logic [31:0] res; logic bd, qa, st;
    v[0] = '{3'b101, 32'h00001234, 32'h0, 32'hFFFFFFFF, 8'd1};
    v[1] = '{3'b111, 32'h00001234, 32'h0, 32'h00001234, 8'd1};
    v[2] = '{3'b100, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFFF, 8'd1};
    v[3] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd1};
    v[4] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 8'd1};
    for (int i = 0; i < 5; i++) begin
      run_op(v[i].f, v[i].a, v[i].b, 1'b0, lat, res, bd, qa, st);
      checks++; if (res !== v[i].r) begin errors++; $display("FAIL fast[%0d]_result got %h exp %h", i, res, v[i].r); end
      checks++; if (lat != int'(v[i].lat)) begin errors++; $display("FAIL fast[%0d]_latency got %0d exp %0d", i, lat, v[i].lat); end
      checks++; if (!(bd && qa)) begin errors++; $display("FAIL fast[%0d]_handshake got busy_done=%b quiet=%b exp 11", i, bd, qa); end
    end
  endtask

  task automatic test_kill();
    int lat; logic [31:0] res; logic bd, qa, st; int seen;
    run_op(3'b000, 32'd3, 32'd5, 1'b0, lat, res, bd, qa, st);
    checks++; if (res !== 32'd15) begin errors++; $display("FAIL kill_setup got %h exp 0000000f", res); end
    Funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_busy got %b exp 0", busy); end
    seen = 0;
    repeat (40) begin if (done === 1'b1) seen++; @(posedge clk); #1; end
    checks++; if (seen != 0) begin errors++; $display("FAIL kill_no_done got %0d pulses exp 0", seen); end
    checks++; if (result !== 32'd15) begin errors++; $display("FAIL kill_result got %h exp 0000000f", result); end
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, res, bd, qa, st);
    checks++; if (res !== 32'hFFFFFFFE) begin errors++; $display("FAIL kill_restart got %h exp fffffffe", res); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] res; logic bd, qa, st;
    run_op(3'b101, 32'd100, 32'd7, 1'b1, lat, res, bd, qa, st);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL hold_result got %h exp 0000000e", res); end
    checks++; if (lat != 34) begin errors++; $display("FAIL hold_latency got %0d exp 34", lat); end
    checks++; if (qa !== 1'b1) begin errors++; $display("FAIL hold_done_cycle_start got quiet=%b exp 1", qa); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] res; logic bd, qa, st; int seen;
    Funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got %b exp 1", busy); end
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rmid_result got %h exp 0", result); end
    seen = 0;
    repeat (40) begin if (done === 1'b1) seen++; @(posedge clk); #1; end
    checks++; if (seen != 0) begin errors++; $display("FAIL rmid_no_done got %0d pulses exp 0", seen); end
    // start raised together with reset is only taken on the first free edge
    reset = 1'b1; start = 1'b1; Funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_start_ignored got busy=%b exp 0", busy); end
    run_op(3'b000, 32'd6, 32'd7, 1'b0, lat, res, bd, qa, st);
    checks++; if (res !== 32'd42) begin errors++; $display("FAIL rst_then_run got %h exp 0000002a", res); end
    checks++; if (lat != 34) begin errors++; $display("FAIL rst_then_latency got %0d exp 34", lat); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; kill = 1'b0; Funct3 = 3'b000; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
